// File: rtl/ode_step_sequencer.sv
// Multi-channel Euler step sequencer: sweeps NUM_CH step engines, then requests an
// interpolator state change, MAX_ITER times per run, with timeouts, abort and error codes.
module ode_step_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int MAX_ITER = 1000,
    parameter int ITER_W   = 16,
    parameter int TIMEOUT  = 4096,
    parameter int TO_W     = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Process,
    input  logic              INT,
    input  logic [NUM_CH-1:0] Euler_End,
    input  logic [NUM_CH-1:0] Error_Flag,
    input  logic              Change_State_End,
    output logic [NUM_CH-1:0] Euler_Enable,
    output logic              Chage_State,
    output logic              Busy,
    output logic              Done_Processing,
    output logic              Error_Out,
    output logic [1:0]        Error_Code,
    output logic [CH_W-1:0]   Error_Ch,
    output logic [ITER_W-1:0] Iter_Count
);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_CHG, S_WAIT_CHG, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0]        ERR_NONE    = 2'b00;
    localparam logic [1:0]        ERR_STEP    = 2'b01;
    localparam logic [1:0]        ERR_TIMEOUT = 2'b10;
    localparam logic [1:0]        ERR_ABORT   = 2'b11;
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT - 1);
    localparam logic [ITER_W-1:0] ITER_LAST   = ITER_W'(MAX_ITER);
    localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);

    state_t              r_state, w_state_nxt;
    logic                r_process_q;
    logic [CH_W-1:0]     r_ch, w_ch_nxt;
    logic [TO_W-1:0]     r_to, w_to_nxt;
    logic [ITER_W-1:0]   r_iter, w_iter_nxt, w_iter_inc;
    logic                r_err_out, w_err_out_nxt;
    logic [1:0]          r_err_code, w_err_code_nxt;
    logic [CH_W-1:0]     r_err_ch, w_err_ch_nxt;
    logic [NUM_CH-1:0]   r_enable;
    logic                r_chg, r_busy, r_done;
    logic                w_start, w_timeout, w_fault;
    logic [1:0]          w_fault_code;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_ch_nxt       = r_ch;
        w_to_nxt       = r_to;
        w_iter_nxt     = r_iter;
        w_err_out_nxt  = r_err_out;
        w_err_code_nxt = r_err_code;
        w_err_ch_nxt   = r_err_ch;
        w_fault        = 1'b0;
        w_fault_code   = ERR_NONE;
        w_start        = Process & ~r_process_q;
        w_timeout      = (r_to == TO_LAST);
        w_iter_inc     = r_iter + ITER_W'(1);

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt    = S_STEP;
                    w_ch_nxt       = '0;
                    w_to_nxt       = '0;
                    w_iter_nxt     = '0;
                    w_err_out_nxt  = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                    w_err_ch_nxt   = '0;
                end
            end
            S_STEP: begin
                w_to_nxt = r_to + TO_W'(1);
                // Abort outranks a step result, which outranks the timeout.
                if (INT) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_ABORT;
                end else if (Euler_End[r_ch] && Error_Flag[r_ch]) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_STEP;
                end else if (Euler_End[r_ch]) begin
                    w_to_nxt = '0;
                    if (r_ch == CH_LAST) w_state_nxt = S_CHG;
                    else                 w_ch_nxt    = r_ch + CH_W'(1);
                end else if (w_timeout) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_TIMEOUT;
                end
            end
            S_CHG: begin
                if (INT) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_ABORT;
                end else begin
                    w_state_nxt = S_WAIT_CHG;
                    w_to_nxt    = '0;
                end
            end
            S_WAIT_CHG: begin
                w_to_nxt = r_to + TO_W'(1);
                if (INT) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_ABORT;
                end else if (Change_State_End) begin
                    w_iter_nxt = w_iter_inc;
                    if (w_iter_inc == ITER_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_STEP;
                        w_ch_nxt    = '0;
                        w_to_nxt    = '0;
                    end
                end else if (w_timeout) begin
                    w_fault      = 1'b1;
                    w_fault_code = ERR_TIMEOUT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: if (!Process) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_fault) begin
            w_state_nxt    = S_ERROR;
            w_err_out_nxt  = 1'b1;
            w_err_code_nxt = w_fault_code;
            w_err_ch_nxt   = r_ch;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_process_q <= 1'b0;
            r_ch        <= '0;
            r_to        <= '0;
            r_iter      <= '0;
            r_err_out   <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_ch    <= '0;
            r_enable    <= '0;
            r_chg       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_process_q <= Process;
            r_ch        <= w_ch_nxt;
            r_to        <= w_to_nxt;
            r_iter      <= w_iter_nxt;
            r_err_out   <= w_err_out_nxt;
            r_err_code  <= w_err_code_nxt;
            r_err_ch    <= w_err_ch_nxt;
            r_enable    <= (w_state_nxt == S_STEP) ? (NUM_CH'(1) << w_ch_nxt) : '0;
            r_chg       <= (w_state_nxt == S_CHG);
            r_busy      <= (w_state_nxt == S_STEP) || (w_state_nxt == S_CHG) ||
                           (w_state_nxt == S_WAIT_CHG);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign Euler_Enable    = r_enable;
    assign Chage_State     = r_chg;
    assign Busy            = r_busy;
    assign Done_Processing = r_done;
    assign Error_Out       = r_err_out;
    assign Error_Code      = r_err_code;
    assign Error_Ch        = r_err_ch;
    assign Iter_Count      = r_iter;

endmodule
